// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C register-file target.
// Holds the target FSM states, bus condition codes and ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK
    } i2c_tgt_state_t;

    typedef enum logic [1:0] {
        COND_NONE = 2'b00,
        START     = 2'b01,
        STOP      = 2'b10
    } i2c_cond_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // True when an address byte {addr[6:0], rw} selects this target.
    function automatic logic addr_hit(input logic [7:0] b,
                                      input logic [6:0] dev);
        return b[7:1] == dev;
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-flop synchronisers for SCL/SDA plus edge/condition detect.
// Ports: CLK, RST (sync, active high), SCL, SDA in; sda_s, scl_rise,
// scl_fall (one-CLK pulses) and cond (COND_NONE/START/STOP pulse) out.
module i2c_bus_sync (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    input  logic       SDA,
    output logic       sda_s,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic [1:0] cond
);
    import i2c_pkg::*;

    // [0],[1] synchroniser; [2] previous synchronised value for edges.
    logic [2:0] scl_sh;
    logic [2:0] sda_sh;
    logic       start_c;
    logic       stop_c;
    i2c_cond_t  cond_c;

    always_ff @(posedge CLK) begin
        if (RST) begin
            scl_sh <= '1;
            sda_sh <= '1;
        end else begin
            scl_sh <= {scl_sh[1:0], SCL};
            sda_sh <= {sda_sh[1:0], SDA};
        end
    end

    assign sda_s    = sda_sh[1];
    assign scl_rise = scl_sh[1] & ~scl_sh[2];
    assign scl_fall = ~scl_sh[1] & scl_sh[2];

    // SCL must be high both before and after the SDA edge.
    assign start_c = scl_sh[1] & scl_sh[2] & ~sda_sh[1] & sda_sh[2];
    assign stop_c  = scl_sh[1] & scl_sh[2] & sda_sh[1] & ~sda_sh[2];

    always_comb begin
        cond_c = COND_NONE;
        unique case (1'b1)
            start_c: cond_c = START;
            stop_c:  cond_c = STOP;
            default: ;
        endcase
    end

    assign cond = cond_c;

endmodule

// File: rtl/i2c_target_mem.sv
// i2c_target_mem: I2C target exposing DEPTH 8-bit registers at DEV_ADDR.
// Ports: CLK, RST (sync, active high), SCL/SDA (master side, async),
// SDA_out/SDA_oe (target drive), ACK, BUSY, WR_STB, WR_DATA[7:0].
// Define I2C_TARGET_AUTOINC_EN to auto-increment the register pointer.
module i2c_target_mem #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       SCL,
    input  logic       SDA,
    output logic       SDA_out,
    output logic       SDA_oe,
    output logic       ACK,
    output logic       BUSY,
    output logic       WR_STB,
    output logic [7:0] WR_DATA
);
    import i2c_pkg::*;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic           sda_s;
    logic           scl_rise;
    logic           scl_fall;
    logic [1:0]     cond;
    logic           start_det;
    logic           stop_det;

    i2c_tgt_state_t state_q, state_n;
    logic [2:0]     cnt_q, cnt_n;
    logic [7:0]     shreg_q, shreg_n;
    logic           rdy_q, rdy_n;
    logic           rw_q, rw_n;
    logic           mack_q, mack_n;
    logic [PW-1:0]  ptr_q, ptr_n;
    logic [PW-1:0]  ptr_inc;
    logic           sda_out_q, sda_out_n;
    logic           sda_oe_q, sda_oe_n;
    logic           ack_q, ack_n;
    logic           busy_q, busy_n;
    logic           we;
    logic           wr_stb_q;
    logic [7:0]     wr_data_q;
    logic [7:0]     rx_byte;
    logic [7:0]     mem [DEPTH];

    i2c_bus_sync u_sync (
        .CLK      (CLK),
        .RST      (RST),
        .SCL      (SCL),
        .SDA      (SDA),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .cond     (cond)
    );

    assign start_det = (cond == START);
    assign stop_det  = (cond == STOP);

    // Byte as it stands after the bit sampled on this SCL rise.
    assign rx_byte = {shreg_q[6:0], sda_s};

`ifdef I2C_TARGET_AUTOINC_EN
    assign ptr_inc = ptr_q + 1'b1;
`else
    assign ptr_inc = ptr_q;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            rdy_q     <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= I2C_NACK;
            ptr_q     <= '0;
            sda_out_q <= 1'b1;
            sda_oe_q  <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            shreg_q   <= shreg_n;
            rdy_q     <= rdy_n;
            rw_q      <= rw_n;
            mack_q    <= mack_n;
            ptr_q     <= ptr_n;
            sda_out_q <= sda_out_n;
            sda_oe_q  <= sda_oe_n;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        shreg_n   = shreg_q;
        rdy_n     = rdy_q;
        rw_n      = rw_q;
        mack_n    = mack_q;
        ptr_n     = ptr_q;
        sda_out_n = sda_out_q;
        sda_oe_n  = sda_oe_q;
        ack_n     = ack_q;
        busy_n    = busy_q;
        we        = 1'b0;

        if (stop_det) begin
            state_n   = IDLE;
            rdy_n     = 1'b0;
            sda_out_n = 1'b1;
            sda_oe_n  = 1'b0;
            ack_n     = 1'b0;
            busy_n    = 1'b0;
        end else if (start_det) begin
            state_n   = ADDR;
            cnt_n     = '0;
            rdy_n     = 1'b0;
            sda_out_n = 1'b1;
            sda_oe_n  = 1'b0;
            ack_n     = 1'b0;
        end else if (scl_rise) begin
            unique case (state_q)
                ADDR, PTR, WDATA: begin
                    shreg_n = rx_byte;
                    cnt_n   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rdy_n = 1'b1;
                        if (state_q == PTR)
                            ptr_n = rx_byte[PW-1:0];
                        if (state_q == WDATA) begin
                            we    = 1'b1;
                            ptr_n = ptr_inc;
                        end
                    end
                end
                RDATA: begin
                    cnt_n = cnt_q + 3'd1;
                    if (cnt_q == 3'd7)
                        rdy_n = 1'b1;
                end
                RDATA_ACK: mack_n = sda_s;
                default: ;
            endcase
        end else if (scl_fall) begin
            unique case (state_q)
                ADDR: begin
                    if (rdy_q) begin
                        rdy_n = 1'b0;
                        if (addr_hit(shreg_q, DEV_ADDR)) begin
                            state_n   = ADDR_ACK;
                            rw_n      = shreg_q[0];
                            sda_out_n = I2C_ACK;
                            sda_oe_n  = 1'b1;
                            ack_n     = 1'b1;
                            busy_n    = 1'b1;
                        end else begin
                            state_n   = IDLE;
                            sda_out_n = 1'b1;
                            sda_oe_n  = 1'b0;
                            busy_n    = 1'b0;
                        end
                    end
                end
                PTR, WDATA: begin
                    if (rdy_q) begin
                        rdy_n     = 1'b0;
                        state_n   = (state_q == PTR) ? PTR_ACK
                                                     : WDATA_ACK;
                        sda_out_n = I2C_ACK;
                        sda_oe_n  = 1'b1;
                        ack_n     = 1'b1;
                    end
                end
                ADDR_ACK: begin
                    cnt_n = '0;
                    ack_n = 1'b0;
                    if (rw_q) begin
                        state_n   = RDATA;
                        shreg_n   = mem[ptr_q];
                        sda_out_n = mem[ptr_q][7];
                        sda_oe_n  = 1'b1;
                    end else begin
                        state_n   = PTR;
                        sda_out_n = 1'b1;
                        sda_oe_n  = 1'b0;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    state_n   = WDATA;
                    cnt_n     = '0;
                    ack_n     = 1'b0;
                    sda_out_n = 1'b1;
                    sda_oe_n  = 1'b0;
                end
                RDATA: begin
                    if (rdy_q) begin
                        rdy_n     = 1'b0;
                        state_n   = RDATA_ACK;
                        sda_out_n = 1'b1;
                        sda_oe_n  = 1'b0;
                    end else begin
                        shreg_n   = {shreg_q[6:0], 1'b0};
                        sda_out_n = shreg_q[6];
                    end
                end
                RDATA_ACK: begin
                    if (mack_q == I2C_NACK) begin
                        state_n = IDLE;
                    end else begin
                        state_n   = RDATA;
                        cnt_n     = '0;
                        ptr_n     = ptr_inc;
                        shreg_n   = mem[ptr_inc];
                        sda_out_n = mem[ptr_inc][7];
                        sda_oe_n  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_stb_q  <= 1'b0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            wr_stb_q <= we;
            if (we) begin
                wr_data_q  <= rx_byte;
                mem[ptr_q] <= rx_byte;
            end
        end
    end

    assign SDA_out = sda_out_q;
    assign SDA_oe  = sda_oe_q;
    assign ACK     = ack_q;
    assign BUSY    = busy_q;
    assign WR_STB  = wr_stb_q;
    assign WR_DATA = wr_data_q;

endmodule

// File: doc/i2c_target_mem.md
I2C_TARGET_MEM -- requirements
Module: i2c_target_mem

Interface
REQ-001 Parameter DEV_ADDR, default 7'h50, 7-bit target address this block answers to.
REQ-002 Parameter DEPTH, default 16, number of 8-bit registers; power of two, 2..256.
REQ-003 CLK  input  1  sole clock; all logic on posedge CLK.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 SCL  input  1  I2C clock from the master, asynchronous to CLK.
REQ-006 SDA  input  1  I2C data line as driven by the master, asynchronous to CLK.
REQ-007 SDA_out  output  1  data this target drives onto SDA; meaningful only while SDA_oe=1.
REQ-008 SDA_oe  output  1  1 = target drives SDA_out, 0 = release the line.
REQ-009 ACK  output  1  high for the whole ACK bit time of any byte this target acknowledges.
REQ-010 BUSY  output  1  high from an address match until STOP or a non-matching START.
REQ-011 WR_STB  output  1  one-CLK pulse when a data byte is committed to memory.
REQ-012 WR_DATA  output  8  byte committed; valid with WR_STB.

Function
REQ-013 SCL and SDA shall pass through 2-flop synchronisers; edges shall be detected on the synchronised signals; SCL high or low phases shall each last at least 4 CLK.
REQ-014 START = SDA falling while SCL high; STOP = SDA rising while SCL high; both shall be recognised in every state.
REQ-015 Bits shall be sampled on the SCL rising edge; SDA_out/SDA_oe shall change only on the SCL falling edge, one CLK after detection.
REQ-016 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK.
REQ-017 IDLE -> ADDR on START; ADDR shifts 8 bits MSB first ({addr[6:0], RW}).
REQ-018 On address match -> ADDR_ACK; drive SDA_oe=1, SDA_out=0 and ACK=1 for one SCL period; on mismatch -> IDLE with SDA_oe=0.
REQ-019 After ADDR_ACK: RW=0 -> PTR; RW=1 -> RDATA, loading the byte at the current pointer.
REQ-020 PTR receives 8 bits; pointer <= byte mod DEPTH; PTR_ACK acknowledges; then -> WDATA.
REQ-021 WDATA receives 8 bits; on the 8th bit: mem[ptr] <= byte, WR_STB pulse, WR_DATA = byte; WDATA_ACK acknowledges; then -> WDATA.
REQ-022 RDATA drives mem[ptr] MSB first; RDATA_ACK releases SDA and samples the master ACK bit: 0 -> reload the next byte into RDATA; 1 (NACK) -> IDLE, wait for STOP/START.
REQ-023 Repeated START in any state -> ADDR; the pointer is retained.
REQ-024 STOP in any state -> IDLE, SDA_oe=0, BUSY=0; a partially received byte is discarded and not written.
REQ-025 The pointer wraps DEPTH-1 -> 0.

Reset
REQ-026 On RST: state IDLE, SDA_oe=0, SDA_out=1, ACK=0, BUSY=0, WR_STB=0, WR_DATA=0, pointer=0, synchronisers=1; memory contents cleared to 8'h00.
REQ-027 RST mid-transfer shall abort immediately with no memory write; the next START is honoured.

Configuration
REQ-028 Macro I2C_TARGET_AUTOINC_EN defined: the pointer increments by 1 after each committed write byte and after each read byte the master ACKs.
REQ-029 Macro undefined: the pointer changes only in PTR; successive bytes access the same register.

Structure
REQ-030 Package i2c_pkg shall hold the state enum i2c_tgt_state_t and the constants START/STOP and the ACK=0 / NACK=1 bit values.
REQ-031 Sub-module i2c_bus_sync: synchronisers plus SCL rise/fall and START/STOP pulse detection.

Verification
REQ-032 Write: START, 0xA0, ptr 0x03, data 0x5A, STOP -> three ACKs; WR_STB once with WR_DATA=0x5A; mem[3]=0x5A.
REQ-033 Read: after REQ-032, START, 0xA0, 0x03, repeated START, 0xA1, master NACK -> SDA_out shifts 0x5A; returns to IDLE.
REQ-034 Address 0xA2 (0x51) -> no ACK, SDA_oe stays 0, BUSY stays 0.
REQ-035 AUTOINC_EN: ptr 0x0F, data 0x11, 0x22 -> mem[15]=0x11, mem[0]=0x22 (wrap); without macro -> mem[15]=0x22.
REQ-036 STOP after 4 data bits -> no WR_STB; RST asserted mid-read -> SDA_oe=0 on the next CLK.
